// File: rtl/adsb_pkg.sv
// ============================================================================
// Module : adsb_pkg
// Shared constants, header layout and helpers for the ADS-B config path.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package adsb_pkg;

   localparam logic [15:0] adsb_config_magic      = 16'hAD5B;
   localparam logic [7:0]  ADSB_CFG_MSG_CONTROL   = 8'h01;
   localparam logic [7:0]  ADSB_CFG_MSG_THRESHOLD = 8'h02;

   // CONTROL payload bit positions
   localparam int ADSB_CTRL_ENABLE_BIT   = 0;
   localparam int ADSB_CTRL_SOFT_RST_BIT = 8;

   // Header word plus payload word
   localparam int adsb_config_width = 64;

   typedef struct packed {
      logic [15:0] magic;
      logic [7:0]  module_id;
      logic [7:0]  msg_type;
   } adsb_config_header_t;

   function automatic logic [15:0] adsb_sat_inc(input logic [15:0] v);
      return (v == 16'hFFFF) ? v : v + 16'd1;
   endfunction

endpackage

`default_nettype wire

// File: rtl/adsb_pulse_timer.sv
// ============================================================================
// Module : adsb_pulse_timer
// Reloadable down-counter; pulse is high while the count is non-zero.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module adsb_pulse_timer #(
   parameter int                    CNT_WIDTH  = 8,
   parameter logic [CNT_WIDTH-1:0]  LOAD_VALUE = 8'd16
) (
   input  logic clk,
   input  logic rst_n,
   input  logic load,
   output logic pulse
);

   logic [CNT_WIDTH-1:0] r_count;

   // A load during an active pulse restarts the full length
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_count <= '0;
      end else if (load) begin
         r_count <= LOAD_VALUE;
      end else if (r_count != '0) begin
         r_count <= r_count - 1'b1;
      end
   end

   assign pulse = (r_count != '0);

endmodule

`default_nettype wire

// File: rtl/adsb_config_controller.sv
// ============================================================================
// Module : adsb_config_controller
// Decodes 2-word AXI-stream config messages into demodulator control regs.
// Optional status counters enabled by macro ADSB_CONFIG_STATUS_EN.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module adsb_config_controller
   import adsb_pkg::*;
#(
   parameter logic [7:0]                 MODULE_ID         = 8'h01,
   parameter int                         AXI_DATA_WIDTH    = 32,
   parameter int                         THRESHOLD_WIDTH   = 16,
   parameter logic [THRESHOLD_WIDTH-1:0] THRESHOLD_DEFAULT = 16'h0100,
   parameter int                         DEMOD_RST_CYCLES  = 16
) (
   input  logic                       S_axis_clk,
   input  logic                       S_axis_resetn,
   input  logic                       S_axis_valid,
   output logic                       S_axis_ready,
   input  logic [AXI_DATA_WIDTH-1:0]  S_axis_data,
   input  logic                       S_axis_last,
   output logic                       Demod_enable,
   output logic [THRESHOLD_WIDTH-1:0] Demod_threshold,
   output logic                       Demod_soft_rst,
   output logic [15:0]                Cfg_msg_count,
   output logic [15:0]                Cfg_err_count
);

   localparam logic [1:0] S_HEADER  = 2'd0;
   localparam logic [1:0] S_PAYLOAD = 2'd1;
   localparam logic [1:0] S_DRAIN   = 2'd2;
   localparam logic [1:0] S_APPLY   = 2'd3;

   logic [1:0]                 r_state;
   logic [1:0]                 w_state_nxt;
   logic                       r_ready_en;
   logic                       w_ready;
   logic                       w_accept;
   logic                       w_magic_ok;
   logic                       w_id_ok;
   logic                       w_hdr_latch;
   logic                       w_pay_latch;
   logic                       w_apply;
   logic                       w_err_inc;
   logic                       w_srst_load;
   logic                       w_soft_rst;
   adsb_config_header_t        w_hdr;

   logic [7:0]                 r_msg_type;
   logic                       r_pay_enable;
   logic                       r_pay_srst;
   logic [THRESHOLD_WIDTH-1:0] r_pay_thresh;
   logic                       r_enable;
   logic [THRESHOLD_WIDTH-1:0] r_threshold;

   assign w_hdr      = S_axis_data;
   assign w_magic_ok = (w_hdr.magic == adsb_config_magic);
   assign w_id_ok    = (w_hdr.module_id == MODULE_ID);
   assign w_accept   = S_axis_valid && w_ready;

   // State register
   always_ff @(posedge S_axis_clk or negedge S_axis_resetn) begin
      if (!S_axis_resetn) begin
         r_state    <= S_HEADER;
         r_ready_en <= 1'b0;
      end else begin
         r_state    <= w_state_nxt;
         r_ready_en <= 1'b1;
      end
   end

   // Next-state logic
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_HEADER: begin
            if (w_accept) begin
               if (S_axis_last)     w_state_nxt = S_HEADER;
               else if (!w_magic_ok) w_state_nxt = S_DRAIN;
               else if (!w_id_ok)    w_state_nxt = S_DRAIN;
               else                  w_state_nxt = S_PAYLOAD;
            end
         end
         S_PAYLOAD: begin
            if (w_accept) w_state_nxt = S_axis_last ? S_APPLY : S_DRAIN;
         end
         S_DRAIN: begin
            if (w_accept && S_axis_last) w_state_nxt = S_HEADER;
         end
         S_APPLY:  w_state_nxt = S_HEADER;
         default:  w_state_nxt = S_HEADER;
      endcase
   end

   // Output / strobe decode
   always_comb begin
      w_ready     = r_ready_en && (r_state != S_APPLY);
      w_hdr_latch = 1'b0;
      w_pay_latch = 1'b0;
      w_apply     = 1'b0;
      w_err_inc   = 1'b0;
      case (r_state)
         S_HEADER: begin
            w_hdr_latch = w_accept && !S_axis_last && w_magic_ok && w_id_ok;
            w_err_inc   = w_accept && (S_axis_last || !w_magic_ok);
         end
         S_PAYLOAD: begin
            w_pay_latch = w_accept && S_axis_last;
            w_err_inc   = w_accept && !S_axis_last;
         end
         S_APPLY:  w_apply = 1'b1;
         default: ;
      endcase
   end

   assign S_axis_ready = w_ready;

   always_ff @(posedge S_axis_clk or negedge S_axis_resetn) begin
      if (!S_axis_resetn) begin
         r_msg_type   <= '0;
         r_pay_enable <= 1'b0;
         r_pay_srst   <= 1'b0;
         r_pay_thresh <= '0;
         r_enable     <= 1'b0;
         r_threshold  <= THRESHOLD_DEFAULT;
      end else begin
         if (w_hdr_latch) r_msg_type <= w_hdr.msg_type;
         if (w_pay_latch) begin
            r_pay_enable <= S_axis_data[ADSB_CTRL_ENABLE_BIT];
            r_pay_srst   <= S_axis_data[ADSB_CTRL_SOFT_RST_BIT];
            r_pay_thresh <= S_axis_data[THRESHOLD_WIDTH-1:0];
         end
         if (w_apply && (r_msg_type == ADSB_CFG_MSG_CONTROL))   r_enable    <= r_pay_enable;
         if (w_apply && (r_msg_type == ADSB_CFG_MSG_THRESHOLD)) r_threshold <= r_pay_thresh;
      end
   end

   assign w_srst_load = w_apply && (r_msg_type == ADSB_CFG_MSG_CONTROL) && r_pay_srst;

   adsb_pulse_timer #(
      .CNT_WIDTH  (8),
      .LOAD_VALUE (8'(DEMOD_RST_CYCLES))
   ) u_pulse_timer (
      .clk   (S_axis_clk),
      .rst_n (S_axis_resetn),
      .load  (w_srst_load),
      .pulse (w_soft_rst)
   );

   // The enable register keeps its value; only the output is masked
   assign Demod_enable    = r_enable && !w_soft_rst;
   assign Demod_threshold = r_threshold;
   assign Demod_soft_rst  = w_soft_rst;

`ifdef ADSB_CONFIG_STATUS_EN
   logic [15:0] r_msg_count;
   logic [15:0] r_err_count;

   always_ff @(posedge S_axis_clk or negedge S_axis_resetn) begin
      if (!S_axis_resetn) begin
         r_msg_count <= '0;
         r_err_count <= '0;
      end else begin
         if (w_apply)   r_msg_count <= adsb_sat_inc(r_msg_count);
         if (w_err_inc) r_err_count <= adsb_sat_inc(r_err_count);
      end
   end

   assign Cfg_msg_count = r_msg_count;
   assign Cfg_err_count = r_err_count;
`else
   logic w_unused_err;
   assign w_unused_err  = w_err_inc;
   assign Cfg_msg_count = '0;
   assign Cfg_err_count = '0;
`endif

endmodule

`default_nettype wire
